// File: rtl/mario_pkg.sv
// rtl/mario_pkg.sv - shared ioctl indices and NVRAM upload state encoding
package mario_pkg;

  localparam logic [7:0] IOCTL_IDX_ROM   = 8'd0;
  localparam logic [7:0] IOCTL_IDX_DIP   = 8'd254;
  localparam logic [7:0] IOCTL_IDX_NVRAM = 8'd4;

  typedef enum logic [1:0] {
    IDLE,
    PAUSE,
    READY,
    FETCH
  } nvram_up_state_t;

endpackage

// File: rtl/nvram_upload.sv
// rtl/nvram_upload.sv - serves HPS upload reads from work RAM port B while the CPU is paused
module nvram_upload
  import mario_pkg::*;
#(
  parameter logic [7:0] INDEX     = IOCTL_IDX_NVRAM,
  parameter int         ADDR_W    = 11,
  parameter int         SIZE      = 2048,
  parameter int         RAM_LAT   = 1,
  parameter int         PAUSE_TMO = 1024
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              upload_done
);

  localparam int TMO_W = $clog2(PAUSE_TMO) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PAUSE_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

  nvram_up_state_t  r_state;
  logic [TMO_W-1:0] r_tmo;
  logic [1:0]       r_lat;
  logic             r_oob;
  logic             r_by_ack;
  logic             w_active;

  assign w_active = ioctl_upload && (ioctl_index == INDEX);

  always_ff @(posedge clk_sys) begin
    ram_rd      <= 1'b0;
    upload_done <= 1'b0;
    if (reset) begin
      r_state    <= IDLE;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      pause_req  <= 1'b0;
      ram_addr   <= '0;
      r_tmo      <= '0;
      r_lat      <= 2'd0;
      r_oob      <= 1'b0;
      r_by_ack   <= 1'b0;
    end else if (r_state != IDLE && !w_active) begin
      // Session over: release the CPU and abandon any in-flight fetch.
      r_state     <= IDLE;
      pause_req   <= 1'b0;
      ioctl_wait  <= 1'b0;
      upload_done <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_active) begin
            r_state    <= PAUSE;
            pause_req  <= 1'b1;
            ioctl_wait <= 1'b1;
            r_tmo      <= '0;
          end
        end
        PAUSE: begin
          if (pause_ack) begin
            r_state    <= READY;
            ioctl_wait <= 1'b0;
            r_by_ack   <= 1'b1;
          end else if (r_tmo == TMO_LAST) begin
            r_state    <= READY;
            ioctl_wait <= 1'b0;
            r_by_ack   <= 1'b0;
          end else if (r_tmo != TMO_MAX) begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        READY: begin
          // Losing the ack means the CPU may own the RAM bus again.
          if (r_by_ack && !pause_ack) begin
            r_state    <= PAUSE;
            ioctl_wait <= 1'b1;
            r_tmo      <= '0;
          end else if (ioctl_rd) begin
            r_state    <= FETCH;
            ioctl_wait <= 1'b1;
            if (ioctl_addr < 25'(SIZE)) begin
              ram_addr <= ioctl_addr[ADDR_W-1:0];
              ram_rd   <= 1'b1;
              r_lat    <= 2'(RAM_LAT);
              r_oob    <= 1'b0;
            end else begin
              r_lat <= 2'd0;
              r_oob <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (r_lat == 2'd0) begin
            r_state    <= READY;
            ioctl_wait <= 1'b0;
            ioctl_din  <= r_oob ? 8'hFF : ram_q;
          end else begin
            r_lat <= r_lat - 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_upload.sv
// tb/tb_nvram_upload.sv - directed and randomized checks of nvram_upload against a session-level model
module tb_nvram_upload;

  localparam int ADDR_W    = 11;
  localparam int SIZE      = 2048;
  localparam int RAM_LAT   = 1;
  localparam int PAUSE_TMO = 1024;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_upload = 1'b0;
  logic [7:0]        ioctl_index = 8'd0;
  logic              ioctl_rd = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              pause_req;
  logic              pause_ack = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              upload_done;

  nvram_upload #(
    .INDEX(8'd4), .ADDR_W(ADDR_W), .SIZE(SIZE), .RAM_LAT(RAM_LAT), .PAUSE_TMO(PAUSE_TMO)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .pause_req(pause_req), .pause_ack(pause_ack), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_q(ram_q), .upload_done(upload_done)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] mem [SIZE];
  logic [7:0] pipe [RAM_LAT];

  always @(posedge clk_sys) begin
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RAM_LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session-level model: a session is live, either waiting for the CPU
  // or serving, and a read keeps the host waiting for a fixed number of cycles.
  bit         m_sess = 0, m_serving = 0, m_by_ack = 0;
  int         m_waited = 0, m_busy = 0;
  logic [7:0] m_pend = 8'h00;
  logic [7:0] e_din = 8'h00;
  logic [ADDR_W-1:0] e_addr = '0;
  bit         e_rd = 0, e_done = 0;
  bit         chk_en = 0;

  always @(posedge clk_sys) begin
    bit act;
    act = ioctl_upload && (ioctl_index == 8'd4);
    e_rd = 0;
    e_done = 0;
    if (reset) begin
      m_sess = 0; m_serving = 0; m_busy = 0; e_din = 8'h00; e_addr = '0;
    end else if (m_sess && !act) begin
      m_sess = 0; m_serving = 0; m_busy = 0; e_done = 1;
    end else if (!m_sess) begin
      if (act) begin m_sess = 1; m_serving = 0; m_waited = 0; end
    end else if (!m_serving) begin
      if (pause_ack) begin m_serving = 1; m_by_ack = 1; end
      else if (m_waited == PAUSE_TMO - 1) begin m_serving = 1; m_by_ack = 0; end
      else m_waited++;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) e_din = m_pend;
    end else if (m_by_ack && !pause_ack) begin
      m_serving = 0; m_waited = 0;
    end else if (ioctl_rd) begin
      if (ioctl_addr < SIZE) begin
        e_rd = 1;
        e_addr = ioctl_addr[ADDR_W-1:0];
        m_pend = mem[ioctl_addr[ADDR_W-1:0]];
        m_busy = RAM_LAT + 1;
      end else begin
        m_pend = 8'hFF;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("din", 32'(ioctl_din), 32'(e_din));
      check("wait", 32'(ioctl_wait), 32'(m_sess && (!m_serving || m_busy > 0)));
      check("pause_req", 32'(pause_req), 32'(m_sess));
      check("ram_rd", 32'(ram_rd), 32'(e_rd));
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      check("upload_done", 32'(upload_done), 32'(e_done));
    end
  end

  task automatic do_read(input logic [24:0] a, output int nw, output int nr,
                         output logic [ADDR_W-1:0] ra);
    nw = 0; nr = 0; ra = '0;
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (ioctl_wait) nw++;
      if (ram_rd) begin nr++; ra = ram_addr; end
      if (!ioctl_wait) break;
      @(negedge clk_sys);
    end
  endtask

  task automatic count_wait(input int lim, input int ack_at, output int n);
    n = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk_sys);
      if (ioctl_wait) n++;
      if (ack_at > 0 && n == ack_at) pause_ack = 1'b1;
      if (!ioctl_wait && n > 0) break;
    end
  endtask

  initial begin
    int nw, nr, n, nq;
    logic [ADDR_W-1:0] ra;
    logic [7:0] din_before;

    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
    mem[11'h123] = 8'h5A;

    @(negedge clk_sys);
    chk_en = 1;
    check("reset_outputs", {ioctl_din, ioctl_wait, pause_req, ram_rd, upload_done, 5'(ram_addr)}, 32'h0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Pause handshake: ack seen on the 7th edge keeps wait high 6 cycles.
    ioctl_upload = 1'b1;
    ioctl_index = 8'd4;
    count_wait(50, 6, n);
    check("pause_wait_cycles", 32'(n), 32'd6);
    check("pause_req_held", 32'(pause_req), 32'd1);

    do_read(25'h123, nw, nr, ra);
    check("rd123_wait", 32'(nw), 32'd2);
    check("rd123_ram_rd", 32'(nr), 32'd1);
    check("rd123_addr", 32'(ra), 32'h123);
    check("rd123_din", 32'(ioctl_din), 32'h5A);

    do_read(25'h800, nw, nr, ra);
    check("rd800_wait", 32'(nw), 32'd1);
    check("rd800_ram_rd", 32'(nr), 32'd0);
    check("rd800_din", 32'(ioctl_din), 32'hFF);
    do_read(25'h1000800, nw, nr, ra);
    check("rd1000800_wait", 32'(nw), 32'd1);
    check("rd1000800_ram_rd", 32'(nr), 32'd0);
    check("rd1000800_din", 32'(ioctl_din), 32'hFF);

    // Second strobe arrives while the first fetch is still in flight.
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h040;
    nq = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_sys);
      if (k == 1) ioctl_rd = 1'b0;
      if (ram_rd) nq++;
    end
    check("b2b_ram_rd_count", 32'(nq), 32'd1);
    check("b2b_din", 32'(ioctl_din), 32'(mem[11'h040]));

    din_before = ioctl_din;
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h123;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("drop_pause_req", 32'(pause_req), 32'd0);
    check("drop_wait", 32'(ioctl_wait), 32'd0);
    check("drop_done", 32'(upload_done), 32'd1);
    check("drop_din_kept", 32'(ioctl_din), 32'(din_before));
    @(negedge clk_sys);
    check("drop_done_one_cycle", 32'(upload_done), 32'd0);
    pause_ack = 1'b0;

    // Foreign index: nothing responds.
    ioctl_upload = 1'b1;
    ioctl_index = 8'd0;
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h010;
    nq = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      if (pause_req || ioctl_wait || ram_rd) nq++;
    end
    check("idx0_ignored", 32'(nq), 32'd0);

    // No ack ever: the timeout releases the host.
    ioctl_index = 8'd4;
    count_wait(1100, 0, n);
    check("timeout_wait_cycles", 32'(n), 32'd1024);
    do_read(25'h123, nw, nr, ra);
    check("timeout_rd_din", 32'(ioctl_din), 32'h5A);
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Reset while a fetch is outstanding.
    pause_ack = 1'b1;
    ioctl_upload = 1'b1;
    count_wait(50, 0, n);
    check("ack_early_wait_cycles", 32'(n), 32'd1);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h123;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    check("rst_fetch_outputs", {ioctl_din, ioctl_wait, pause_req, ram_rd, upload_done, 5'(ram_addr)}, 32'h0);
    reset = 1'b0;
    ioctl_upload = 1'b0;
    pause_ack = 1'b0;
    @(negedge clk_sys);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_sys);
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 149) == 0) begin
        ioctl_upload = ~ioctl_upload;
        ioctl_index = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'd4;
      end
      if ($urandom_range(0, 15) == 0) pause_ack = ~pause_ack;
      ioctl_rd = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0: ioctl_addr = 25'($urandom_range(0, SIZE - 1));
        1: ioctl_addr = 25'($urandom_range(SIZE, 2 * SIZE - 1));
        default: ioctl_addr = 25'($urandom);
      endcase
    end
    @(negedge clk_sys);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
